wfq_rank_issue_sched: RTL and testbench

Issue scheduler in front of the WFQ/PIFO rank calculator. It shares the single rank-calc pipeline between NUM_REQ ingress requesters using round-robin arbitration. It blocks issue of a flow whose previous packet is still in the calculator, because per-flow round state is read-modify-written CALC_LATENCY cycles after issue. It routes each returned rank back to the requester that issued it.

---
 rtl/wfq_sched_pkg.sv | 41 ++++
 rtl/wfq_rank_issue_sched_rr_arbiter.sv | 27 ++
 rtl/wfq_rank_issue_sched.sv | 98 +++++++++
 tb/tb_wfq_rank_issue_sched.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/wfq_sched_pkg.sv
// Shared field layout, port-id mapping and tracker entry type for the WFQ rank issue scheduler.
package wfq_sched_pkg;

  localparam int PORT_WIDTH     = 8;
  localparam int CLASS_WIDTH    = 5;
  localparam int PKT_SIZE_WIDTH = 11;
  localparam int PORT_ID_WIDTH  = 3;
  localparam int ID_WIDTH       = PORT_ID_WIDTH + CLASS_WIDTH;
  localparam int TAG_WIDTH      = 2;

  // Request word is {pkt_size, port, class}, class in the low bits.
  localparam int CLASS_LSB      = 0;
  localparam int PORT_LSB       = CLASS_LSB + CLASS_WIDTH;
  localparam int SIZE_LSB       = PORT_LSB + PORT_WIDTH;
  localparam int REQ_DATA_WIDTH = SIZE_LSB + PKT_SIZE_WIDTH;

  localparam logic [PORT_WIDTH-1:0] PORT0_ONEHOT = 8'h01;
  localparam logic [PORT_WIDTH-1:0] PORT1_ONEHOT = 8'h04;
  localparam logic [PORT_WIDTH-1:0] PORT2_ONEHOT = 8'h10;
  localparam logic [PORT_WIDTH-1:0] PORT3_ONEHOT = 8'h40;
  localparam logic [PORT_ID_WIDTH-1:0] CPU_PORT_ID = 3'd4;

  typedef struct packed {
    logic                 v;
    logic [ID_WIDTH-1:0]  id;
    logic [TAG_WIDTH-1:0] tag;
  } trk_entry_t;

  localparam int TRK_ENTRY_WIDTH = 1 + ID_WIDTH + TAG_WIDTH;

  function automatic logic [PORT_ID_WIDTH-1:0] port_to_id(input logic [PORT_WIDTH-1:0] port);
    case (port)
      PORT0_ONEHOT: return 3'd0;
      PORT1_ONEHOT: return 3'd1;
      PORT2_ONEHOT: return 3'd2;
      PORT3_ONEHOT: return 3'd3;
      default:      return CPU_PORT_ID;
    endcase
  endfunction

endpackage

// File: rtl/wfq_rank_issue_sched_rr_arbiter.sv
// Rotating-priority arbiter: first eligible requester at or above rr_ptr, wrapping.
module rr_arbiter
  import wfq_sched_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]   elig,
  input  logic [TAG_WIDTH-1:0] rr_ptr,
  output logic [NUM_REQ-1:0]   gnt,
  output logic [TAG_WIDTH-1:0] gnt_idx,
  output logic                 gnt_any
);

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    for (int off = 0; off < NUM_REQ; off++) begin
      if (!gnt_any && elig[(int'(rr_ptr) + off) % NUM_REQ]) begin
        gnt_any = 1'b1;
        gnt_idx = TAG_WIDTH'((int'(rr_ptr) + off) % NUM_REQ);
        gnt[(int'(rr_ptr) + off) % NUM_REQ] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wfq_rank_issue_sched.sv
// Shares one rank-calc pipeline between NUM_REQ requesters, holding off any flow still in flight
// and steering each returned rank back to the requester that issued it.
module wfq_rank_issue_sched
  import wfq_sched_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int RESULT_WIDTH = 32,
  parameter int CALC_LATENCY = 6,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                              clk_dp,
  input  logic                              rst,
  input  logic                              sched_en,
  input  logic [NUM_REQ-1:0]                req_valid,
  input  logic [NUM_REQ*REQ_DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]                req_ready,
  output logic                              calc_in_VALID,
  output logic [REQ_DATA_WIDTH-1:0]         calc_in_DATA,
  input  logic                              calc_out_VALID,
  input  logic [RESULT_WIDTH-1:0]           calc_out_DATA,
  output logic [NUM_REQ-1:0]                rsp_valid,
  output logic [RESULT_WIDTH-1:0]           rsp_data,
  output logic                              err_sticky,
  output logic [CNT_WIDTH-1:0]              hazard_stall_cnt
);

  logic [NUM_REQ-1:0][REQ_DATA_WIDTH-1:0] req_word;
  logic [NUM_REQ-1:0][ID_WIDTH-1:0]       flow_id;
  logic [NUM_REQ-1:0]                     hazard;
  logic [NUM_REQ-1:0]                     elig;
  logic [NUM_REQ-1:0]                     gnt;
  logic [TAG_WIDTH-1:0]                   gnt_idx;
  logic [TAG_WIDTH-1:0]                   rr_ptr;
  logic                                   gnt_any;

  // trk[] spans the hazard window; ret is the entry whose result is on calc_out this cycle.
  trk_entry_t trk [CALC_LATENCY];
  trk_entry_t ret;

  assign req_word = req_data;

  always_comb begin
    flow_id = '0;
    hazard  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      flow_id[i] = {port_to_id(req_word[i][PORT_LSB +: PORT_WIDTH]),
                    req_word[i][CLASS_LSB +: CLASS_WIDTH]};
      for (int k = 0; k < CALC_LATENCY; k++) begin
        if (trk[k].v && (trk[k].id == flow_id[i])) hazard[i] = 1'b1;
      end
    end
  end

  // rst gating keeps req_ready low while reset is held even with requests pending.
  assign elig      = req_valid & ~hazard & {NUM_REQ{sched_en & rst}};
  assign req_ready = gnt;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .elig    (elig),
    .rr_ptr  (rr_ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_any (gnt_any)
  );

  always_ff @(posedge clk_dp or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < CALC_LATENCY; k++) trk[k] <= '0;
      ret              <= '0;
      rr_ptr           <= '0;
      calc_in_VALID    <= 1'b0;
      calc_in_DATA     <= '0;
      rsp_valid        <= '0;
      rsp_data         <= '0;
      err_sticky       <= 1'b0;
      hazard_stall_cnt <= '0;
    end else begin
      trk[0] <= gnt_any ? '{v: 1'b1, id: flow_id[gnt_idx], tag: gnt_idx} : '0;
      for (int k = 1; k < CALC_LATENCY; k++) trk[k] <= trk[k-1];
      ret <= trk[CALC_LATENCY-1];

      calc_in_VALID <= gnt_any;
      if (gnt_any) begin
        calc_in_DATA <= req_word[gnt_idx];
        rr_ptr       <= (gnt_idx == TAG_WIDTH'(NUM_REQ - 1)) ? '0 : gnt_idx + TAG_WIDTH'(1);
      end

      // A spurious result is flagged but never delivered; a missing one simply drops its tag.
      rsp_valid <= (calc_out_VALID && ret.v) ? (NUM_REQ'(1) << ret.tag) : '0;
      if (calc_out_VALID) rsp_data <= calc_out_DATA;
      if (calc_out_VALID != ret.v) err_sticky <= 1'b1;

      if (sched_en && (|req_valid) && !gnt_any && (hazard_stall_cnt != '1))
        hazard_stall_cnt <= hazard_stall_cnt + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_wfq_rank_issue_sched.sv
// Directed and randomized bench with a cycle-level reference model and an emulated rank calculator.
module tb_wfq_rank_issue_sched;
  localparam int N = 4, LAT = 6, DW = 24, RW = 32, CW = 16;

  logic            clk_dp = 1'b0;
  logic            rst = 1'b0;
  logic            sched_en = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N*DW-1:0] req_data = '0;
  logic [N-1:0]    req_ready;
  logic            calc_in_VALID;
  logic [DW-1:0]   calc_in_DATA;
  logic            calc_out_VALID = 1'b0;
  logic [RW-1:0]   calc_out_DATA = '0;
  logic [N-1:0]    rsp_valid;
  logic [RW-1:0]   rsp_data;
  logic            err_sticky;
  logic [CW-1:0]   hazard_stall_cnt;

  always #5 clk_dp = ~clk_dp;

  wfq_rank_issue_sched dut (
    .clk_dp(clk_dp), .rst(rst), .sched_en(sched_en),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .calc_in_VALID(calc_in_VALID), .calc_in_DATA(calc_in_DATA),
    .calc_out_VALID(calc_out_VALID), .calc_out_DATA(calc_out_DATA),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .err_sticky(err_sticky), .hazard_stall_cnt(hazard_stall_cnt)
  );

  int checks = 0, failures = 0, cyc = 0;
  logic [DW-1:0] rd [N];
  bit refill = 0;
  int ports [6] = '{1, 4, 16, 64, 3, 128};

  // Reference model: flow id -> last issue cycle, response due cycle -> tag, result per output cycle.
  int            last_issue [int];
  int            exp_tag [int];
  logic [RW-1:0] calc_res [int];
  int            mptr = 0;
  int            exp_cnt = 0;
  logic          exp_err = 1'b0;
  logic          exp_civ = 1'b0;
  logic [DW-1:0] exp_cid = '0;
  logic [CW-1:0] c0;

  function automatic int flow_of(input logic [DW-1:0] w);
    int pid;
    case (w[12:5])
      8'h01: pid = 0;
      8'h04: pid = 1;
      8'h10: pid = 2;
      8'h40: pid = 3;
      default: pid = 4;
    endcase
    return pid * 32 + int'(w[4:0]);
  endfunction

  function automatic logic [DW-1:0] mk(input int size, input int port, input int cls);
    return {11'(size), 8'(port), 5'(cls)};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    int g;
    int i;
    logic [N-1:0] one;
    one = 1;
    for (int k = 0; k < N; k++) req_data[k*DW +: DW] = rd[k];
    @(negedge clk_dp);
    g = -1;
    for (int off = 0; off < N; off++) begin
      i = (mptr + off) % N;
      if (g < 0 && req_valid[i] && sched_en &&
          !(last_issue.exists(flow_of(rd[i])) && (cyc - last_issue[flow_of(rd[i])] <= LAT)))
        g = i;
    end
    check("req_ready", 64'(req_ready), (g >= 0) ? 64'(one << g) : 64'd0);
    check("calc_in_VALID", 64'(calc_in_VALID), 64'(exp_civ));
    if (exp_civ) check("calc_in_DATA", 64'(calc_in_DATA), 64'(exp_cid));
    if (exp_tag.exists(cyc)) begin
      check("rsp_valid", 64'(rsp_valid), 64'(one << exp_tag[cyc]));
      check("rsp_data", 64'(rsp_data), 64'(calc_res[cyc-1]));
      exp_tag.delete(cyc);
    end else begin
      check("rsp_idle", 64'(rsp_valid), 64'd0);
    end
    check("hazard_cnt", 64'(hazard_stall_cnt), 64'(exp_cnt));
    check("err_sticky", 64'(err_sticky), 64'(exp_err));
    // Emulated calculator: result appears LAT cycles after calc_in_VALID.
    if (calc_in_VALID) calc_res[cyc + LAT] = $urandom();
    if (calc_out_VALID != exp_tag.exists(cyc + 1)) exp_err = 1'b1;
    exp_civ = (g >= 0);
    if (g >= 0) begin
      last_issue[flow_of(rd[g])] = cyc;
      exp_cid = rd[g];
      mptr = (g + 1) % N;
      exp_tag[cyc + LAT + 2] = g;
    end else if (sched_en && (|req_valid) && exp_cnt < 65535) begin
      exp_cnt++;
    end
    @(posedge clk_dp);
    #1;
    cyc++;
    calc_out_VALID = calc_res.exists(cyc);
    calc_out_DATA  = calc_res.exists(cyc) ? calc_res[cyc] : RW'($urandom());
    if (g >= 0) req_valid[g] = 1'b0;
    if (refill) begin
      for (int k = 0; k < N; k++) begin
        if (!req_valid[k] && $urandom_range(0, 2) != 0) begin
          rd[k] = mk($urandom_range(64, 1500), ports[$urandom_range(0, 5)], $urandom_range(0, 3));
          req_valid[k] = 1'b1;
        end
      end
      sched_en = ($urandom_range(0, 9) != 0);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_req_ready"}, 64'(req_ready), 64'd0);
    check({tag, "_calc_in_VALID"}, 64'(calc_in_VALID), 64'd0);
    check({tag, "_calc_in_DATA"}, 64'(calc_in_DATA), 64'd0);
    check({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
    check({tag, "_rsp_data"}, 64'(rsp_data), 64'd0);
    check({tag, "_err_sticky"}, 64'(err_sticky), 64'd0);
    check({tag, "_hazard_cnt"}, 64'(hazard_stall_cnt), 64'd0);
  endtask

  initial begin
    for (int k = 0; k < N; k++) rd[k] = mk(100 + k, ports[k], k);
    // Reset held with requests pending: nothing may be granted.
    req_valid = '1;
    sched_en  = 1'b1;
    for (int k = 0; k < N; k++) req_data[k*DW +: DW] = rd[k];
    repeat (2) @(posedge clk_dp);
    @(negedge clk_dp);
    check_all_zero("reset");
    req_valid = '0;
    @(posedge clk_dp);
    #1;
    rst = 1'b1;
    cyc = 0;

    // Round-robin over four distinct flows: grants 0,1,2,3,0.
    for (int k = 0; k < N; k++) rd[k] = mk(64 + k, ports[k], 5 + k);
    req_valid = '1;
    tick();
    rd[0] = mk(200, 8'h01, 9);
    req_valid[0] = 1'b1;
    repeat (4) tick();
    repeat (10) tick();

    // Single request: port 0x04, class 3, size 100.
    rd[0] = mk(100, 8'h04, 3);
    req_valid[0] = 1'b1;
    repeat (10) tick();

    // Two requesters on the same flow {1,3}: second grant 7 cycles later.
    rd[0] = mk(100, 8'h04, 3);
    rd[1] = mk(120, 8'h04, 3);
    req_valid[1:0] = 2'b11;
    c0 = hazard_stall_cnt;
    repeat (9) tick();
    check("hazard_delta", 64'(CW'(hazard_stall_cnt - c0)), 64'd6);
    repeat (8) tick();

    // Bypass: blocked requester at rr_ptr is skipped in favour of another flow.
    rd[0] = mk(300, 8'h10, 7);
    req_valid[0] = 1'b1;
    tick();
    rd[1] = mk(310, 8'h10, 7);
    rd[2] = mk(320, 8'h40, 2);
    req_valid[2:1] = 2'b11;
    tick();
    repeat (10) tick();

    // Three in flight, then sched_en low for 10 cycles.
    for (int k = 0; k < 3; k++) rd[k] = mk(400 + k, ports[k], 12 + k);
    req_valid = 4'b0111;
    repeat (3) tick();
    sched_en = 1'b0;
    for (int k = 0; k < N; k++) rd[k] = mk(500 + k, ports[k], 20 + k);
    req_valid = '1;
    c0 = hazard_stall_cnt;
    repeat (10) tick();
    check("en_off_cnt_hold", 64'(hazard_stall_cnt), 64'(c0));
    sched_en = 1'b1;
    repeat (14) tick();

    // Spurious result with an empty tracker.
    calc_out_VALID = 1'b1;
    calc_out_DATA  = 32'hDEAD_BEEF;
    tick();
    tick();
    check("err_after_spurious", 64'(err_sticky), 64'd1);

    // Random traffic, asynchronous reset mid-stream, more random traffic.
    refill = 1;
    repeat (250) tick();
    #1;
    rst = 1'b0;
    #1;
    check_all_zero("midreset");
    last_issue.delete();
    exp_tag.delete();
    calc_res.delete();
    mptr = 0; exp_cnt = 0; exp_err = 1'b0; exp_civ = 1'b0;
    calc_out_VALID = 1'b0;
    req_valid = '0;
    @(posedge clk_dp);
    #1;
    cyc++;
    rst = 1'b1;
    repeat (250) tick();
    refill = 0;
    sched_en = 1'b1;
    repeat (20) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
